// File: rtl/decode_regfile_pkg.sv
// Shared definitions for the decode/register-file stage: processor state
// encodings, opcode/funct constants and small decode helpers.
package decode_regfile_pkg;

    // Global processor state as broadcast by the sequencer.
    typedef enum logic [2:0] {
        STATE_IF = 3'd0,
        STATE_ID = 3'd1,
        STATE_EX = 3'd2,
        STATE_WB = 3'd3
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    // Instruction word split into the R-type fields; the I-type immediate
    // overlaps rd/shamt/funct and is extracted with imm_of().
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    // True for the encodings this datapath can execute.
    function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        case (op)
            OP_ADDIU: ok = 1'b1;
            OP_RTYPE: ok = (fn == FN_ADDU) || (fn == FN_SUBU);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Sign-extend the 16-bit immediate held in the low half of the word.
    function automatic logic [31:0] imm_of(input logic [31:0] word);
        return {{16{word[15]}}, word[15:0]};
    endfunction

endpackage

// File: rtl/decode_regfile_if.sv
// Bus between the sequencer/fetch/execute side (master) and the
// decode/register-file stage (slave). No handshakes: state sequences all.
interface decode_regfile_if;
    logic [2:0]  state;
    logic [31:0] instruction;
    logic [31:0] wb_data;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  dest_reg;
    logic        is_rtype;
    logic        illegal;
    logic [7:0]  retired;

    modport master (
        output state, instruction, wb_data,
        input  rs_data, rt_data, imm_ext, opcode, funct,
               dest_reg, is_rtype, illegal, retired
    );

    modport slave (
        input  state, instruction, wb_data,
        output rs_data, rt_data, imm_ext, opcode, funct,
               dest_reg, is_rtype, illegal, retired
    );
endinterface

// File: rtl/decode_regfile_regfile.sv
// NREGS x 32 register file: two asynchronous read ports, one synchronous
// write port, synchronous active-high reset. Index 0 is hard-wired to zero:
// writes to it are dropped and reads of it return zero.
module regfile #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra_addr,
    output logic [31:0] ra_data,
    input  logic [4:0]  rb_addr,
    output logic [31:0] rb_data,
    input  logic        we,
    input  logic [4:0]  wa_addr,
    input  logic [31:0] wa_data
);

    logic [31:0] regs_q [NREGS];
    logic [31:0] regs_d [NREGS];

    // Next-state storage: copy current contents, then apply a gated write.
    always_comb begin
        regs_d = regs_q;
        if (we && (wa_addr != 5'd0) && (32'(wa_addr) < NREGS)) begin
            regs_d[wa_addr] = wa_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Storage flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Asynchronous read ports; register 0 and out-of-range indices read zero.
    always_comb begin
        ra_data = 32'd0;
        rb_data = 32'd0;
        if ((ra_addr != 5'd0) && (32'(ra_addr) < NREGS)) begin
            ra_data = regs_q[ra_addr];
        end else begin
            ra_data = 32'd0;
        end
        if ((rb_addr != 5'd0) && (32'(rb_addr) < NREGS)) begin
            rb_data = regs_q[rb_addr];
        end else begin
            rb_data = 32'd0;
        end
    end

endmodule

// File: rtl/decode_regfile.sv
// decode_regfile: instruction decode + register file stage of the
// multi-cycle MIPS-subset datapath. In STATE_ID it registers the decoded
// fields and both source operands; in STATE_WB it writes the execute result
// to the destination chosen at decode and bumps the retired counter.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN -- flags unsupported
// encodings and suppresses their write-back.
module decode_regfile
    import decode_regfile_pkg::*;
#(
    parameter int NREGS = 32
) (
    input logic            clk,
    input logic            rst,
    decode_regfile_if.slave bus
);

    instr_t      instr_s;
    logic [31:0] rf_rs_s;
    logic [31:0] rf_rt_s;
    logic        rf_we_s;
    logic        illegal_s;
    logic [4:0]  dest_s;
    logic        unused_shamt_s;

    logic [31:0] rs_data_q,  rs_data_d;
    logic [31:0] rt_data_q,  rt_data_d;
    logic [31:0] imm_ext_q,  imm_ext_d;
    logic [5:0]  opcode_q,   opcode_d;
    logic [5:0]  funct_q,    funct_d;
    logic [4:0]  dest_reg_q, dest_reg_d;
    logic        is_rtype_q, is_rtype_d;
    logic        illegal_q,  illegal_d;
    logic [7:0]  retired_q,  retired_d;
    logic        wr_pending_q, wr_pending_d;

    assign instr_s        = instr_t'(bus.instruction);
    assign unused_shamt_s = ^instr_s.shamt;

    // Operands are read straight from the fetched word's rs/rt fields so they
    // can be registered at the ID edge alongside the decoded fields.
    regfile #(.NREGS(NREGS)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (instr_s.rs),
        .ra_data (rf_rs_s),
        .rb_addr (instr_s.rt),
        .rb_data (rf_rt_s),
        .we      (rf_we_s),
        .wa_addr (dest_reg_q),
        .wa_data (bus.wb_data)
    );

    // Combinational decode of the current instruction word.
    always_comb begin
`ifdef DECODE_ILLEGAL_CHECK_EN
        illegal_s = !is_supported(instr_s.opcode, instr_s.funct);
`else
        illegal_s = 1'b0;
`endif
        if (instr_s.opcode == OP_RTYPE) begin
            dest_s = instr_s.rd;
        end else begin
            dest_s = instr_s.rt;
        end
    end

    // Next-state for outputs, pending flag and register-file write enable.
    always_comb begin
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_ext_d    = imm_ext_q;
        opcode_d     = opcode_q;
        funct_d      = funct_q;
        dest_reg_d   = dest_reg_q;
        is_rtype_d   = is_rtype_q;
        illegal_d    = illegal_q;
        retired_d    = retired_q;
        wr_pending_d = wr_pending_q;
        rf_we_s      = 1'b0;
        case (bus.state)
            STATE_ID: begin
                rs_data_d    = rf_rs_s;
                rt_data_d    = rf_rt_s;
                imm_ext_d    = imm_of(bus.instruction);
                opcode_d     = instr_s.opcode;
                funct_d      = instr_s.funct;
                dest_reg_d   = dest_s;
                is_rtype_d   = (instr_s.opcode == OP_RTYPE);
                illegal_d    = illegal_s;
                wr_pending_d = !illegal_s;
            end
            STATE_WB: begin
                if (wr_pending_q) begin
                    rf_we_s      = !rst;
                    retired_d    = retired_q + 8'd1;
                    wr_pending_d = 1'b0;
                end else begin
                    rf_we_s      = 1'b0;
                end
            end
            default: begin
                rf_we_s = 1'b0;
            end
        endcase
    end

    // Stage flops; reset overrides every state action and cancels a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_data_q    <= 32'd0;
            rt_data_q    <= 32'd0;
            imm_ext_q    <= 32'd0;
            opcode_q     <= 6'd0;
            funct_q      <= 6'd0;
            dest_reg_q   <= 5'd0;
            is_rtype_q   <= 1'b0;
            illegal_q    <= 1'b0;
            retired_q    <= 8'd0;
            wr_pending_q <= 1'b0;
        end else begin
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_ext_q    <= imm_ext_d;
            opcode_q     <= opcode_d;
            funct_q      <= funct_d;
            dest_reg_q   <= dest_reg_d;
            is_rtype_q   <= is_rtype_d;
            illegal_q    <= illegal_d;
            retired_q    <= retired_d;
            wr_pending_q <= wr_pending_d;
        end
    end

    assign bus.rs_data  = rs_data_q;
    assign bus.rt_data  = rt_data_q;
    assign bus.imm_ext  = imm_ext_q;
    assign bus.opcode   = opcode_q;
    assign bus.funct    = funct_q;
    assign bus.dest_reg = dest_reg_q;
    assign bus.is_rtype = is_rtype_q;
    assign bus.illegal  = illegal_q;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_decode_regfile.sv
// Directed self-checking bench for decode_regfile.
module tb_decode_regfile;
    import decode_regfile_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    decode_regfile_if bus ();

    decode_regfile #(.NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with given inputs; outputs sampled 1ns after the edge.
    task automatic step(input logic [2:0] st, input logic [31:0] ins, input logic [31:0] wb);
        @(negedge clk);
        bus.state       = st;
        bus.instruction = ins;
        bus.wb_data     = wb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.state = STATE_IF; bus.instruction = 32'hFFFF_FFFF; bus.wb_data = 32'hFFFF_FFFF;
        do_reset();
        checks++; if (bus.rs_data !== 32'd0) begin errors++; $display("FAIL reset_rs: got %h want 0", bus.rs_data); end
        checks++; if (bus.imm_ext !== 32'd0) begin errors++; $display("FAIL reset_imm: got %h want 0", bus.imm_ext); end
        checks++; if (bus.dest_reg !== 5'd0 || bus.opcode !== 6'd0 || bus.funct !== 6'd0 || bus.is_rtype !== 1'b0 || bus.illegal !== 1'b0)
            begin errors++; $display("FAIL reset_fields: dest %h op %h fn %h rt %b il %b want all 0", bus.dest_reg, bus.opcode, bus.funct, bus.is_rtype, bus.illegal); end
        checks++; if (bus.retired !== 8'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", bus.retired); end
    endtask

    task automatic test_addiu();
        step(STATE_IF, 32'h2401_002D, 32'd0);
        step(STATE_ID, 32'h2401_002D, 32'd0);
        checks++; if (bus.dest_reg !== 5'd1) begin errors++; $display("FAIL addiu_dest: got %0d want 1", bus.dest_reg); end
        checks++; if (bus.imm_ext !== 32'h0000_002D) begin errors++; $display("FAIL addiu_imm: got %h want 0000002d", bus.imm_ext); end
        checks++; if (bus.rs_data !== 32'd0) begin errors++; $display("FAIL addiu_rs: got %h want 0", bus.rs_data); end
        checks++; if (bus.opcode !== 6'b001001 || bus.is_rtype !== 1'b0) begin errors++; $display("FAIL addiu_op: op %b rtype %b want 001001/0", bus.opcode, bus.is_rtype); end
        step(STATE_EX, 32'hDEAD_BEEF, 32'd0);
        checks++; if (bus.imm_ext !== 32'h0000_002D) begin errors++; $display("FAIL ex_hold: imm got %h want 0000002d", bus.imm_ext); end
        step(STATE_WB, 32'hDEAD_BEEF, 32'd45);
        checks++; if (bus.retired !== 8'd1) begin errors++; $display("FAIL addiu_retired: got %0d want 1", bus.retired); end
    endtask

    task automatic test_sign_ext();
        step(STATE_ID, 32'h2403_FFC4, 32'd0);
        checks++; if (bus.imm_ext !== 32'hFFFF_FFC4) begin errors++; $display("FAIL signext_imm: got %h want ffffffc4", bus.imm_ext); end
        checks++; if (bus.dest_reg !== 5'd3) begin errors++; $display("FAIL signext_dest: got %0d want 3", bus.dest_reg); end
        step(STATE_WB, 32'd0, 32'hFFFF_FFC4);
        checks++; if (bus.retired !== 8'd2) begin errors++; $display("FAIL signext_retired: got %0d want 2", bus.retired); end
    endtask

    task automatic test_operands();
        // addiu $2,$0,-20
        step(STATE_ID, 32'h2402_FFEC, 32'd0);
        step(STATE_WB, 32'd0, 32'hFFFF_FFEC);
        // addu $5,$1,$2
        step(STATE_ID, 32'h0022_2821, 32'd0);
        checks++; if (bus.rs_data !== 32'd45) begin errors++; $display("FAIL addu_rs: got %h want 0000002d", bus.rs_data); end
        checks++; if (bus.rt_data !== 32'hFFFF_FFEC) begin errors++; $display("FAIL addu_rt: got %h want ffffffec", bus.rt_data); end
        checks++; if (bus.dest_reg !== 5'd5 || bus.is_rtype !== 1'b1) begin errors++; $display("FAIL addu_dest: dest %0d rtype %b want 5/1", bus.dest_reg, bus.is_rtype); end
        checks++; if (bus.funct !== 6'b100001 || bus.opcode !== 6'd0) begin errors++; $display("FAIL addu_funct: fn %b op %b want 100001/000000", bus.funct, bus.opcode); end
        step(STATE_WB, 32'd0, 32'h0000_0019);
        checks++; if (bus.retired !== 8'd4) begin errors++; $display("FAIL addu_retired: got %0d want 4", bus.retired); end
        // subu $6,$5,$3 reads back both earlier results
        step(STATE_ID, 32'h00A3_3023, 32'd0);
        checks++; if (bus.rs_data !== 32'h0000_0019) begin errors++; $display("FAIL subu_rs: got %h want 00000019", bus.rs_data); end
        checks++; if (bus.rt_data !== 32'hFFFF_FFC4) begin errors++; $display("FAIL subu_rt: got %h want ffffffc4", bus.rt_data); end
        checks++; if (bus.dest_reg !== 5'd6 || bus.funct !== 6'b100011) begin errors++; $display("FAIL subu_dest: dest %0d fn %b want 6/100011", bus.dest_reg, bus.funct); end
    endtask

    task automatic test_reg0();
        // addiu $0,$0,7
        step(STATE_ID, 32'h2400_0007, 32'd0);
        step(STATE_WB, 32'd0, 32'd7);
        checks++; if (bus.retired !== 8'd5) begin errors++; $display("FAIL reg0_retired: got %0d want 5", bus.retired); end
        step(STATE_WB, 32'd0, 32'd7);
        checks++; if (bus.retired !== 8'd5) begin errors++; $display("FAIL double_wb: got %0d want 5", bus.retired); end
        // addu $7,$0,$0
        step(STATE_ID, 32'h0000_3821, 32'd0);
        checks++; if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin errors++; $display("FAIL reg0_read: rs %h rt %h want 0/0", bus.rs_data, bus.rt_data); end
    endtask

    task automatic test_reset_midop();
        // addiu $4,$0,1 then reset before WB
        step(STATE_ID, 32'h2404_0001, 32'd0);
        @(negedge clk); rst = 1'b1; bus.state = STATE_EX;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        checks++; if (bus.dest_reg !== 5'd0 || bus.imm_ext !== 32'd0 || bus.retired !== 8'd0) begin errors++; $display("FAIL midop_outputs: dest %0d imm %h ret %0d want 0", bus.dest_reg, bus.imm_ext, bus.retired); end
        step(STATE_WB, 32'd0, 32'h0000_0055);
        checks++; if (bus.retired !== 8'd0) begin errors++; $display("FAIL midop_wb: got %0d want 0", bus.retired); end
        // addu $8,$4,$1: $4 never written, $1 cleared by reset
        step(STATE_ID, 32'h0081_4021, 32'd0);
        checks++; if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin errors++; $display("FAIL midop_regs: rs %h rt %h want 0/0", bus.rs_data, bus.rt_data); end
        step(STATE_WB, 32'd0, 32'd0);
    endtask

    task automatic test_illegal();
        logic       exp_ill;
        logic [7:0] exp_ret;
`ifdef DECODE_ILLEGAL_CHECK_EN
        exp_ill = 1'b1;
        exp_ret = 8'd1;
`else
        exp_ill = 1'b0;
        exp_ret = 8'd2;
`endif
        step(STATE_ID, 32'hFC00_0000, 32'd0);
        checks++; if (bus.illegal !== exp_ill) begin errors++; $display("FAIL illegal_flag: got %b want %b", bus.illegal, exp_ill); end
        checks++; if (bus.opcode !== 6'b111111) begin errors++; $display("FAIL illegal_op: got %b want 111111", bus.opcode); end
        step(STATE_WB, 32'd0, 32'h0000_1234);
        checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL illegal_retired: got %0d want %0d", bus.retired, exp_ret); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 255; i++) begin
            step(STATE_ID, 32'h2409_0000, 32'd0);
            step(STATE_WB, 32'd0, 32'(i));
        end
        checks++; if (bus.retired !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", bus.retired); end
        step(STATE_ID, 32'h2409_0000, 32'd0);
        step(STATE_WB, 32'd0, 32'h0000_ABCD);
        checks++; if (bus.retired !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d want 0", bus.retired); end
        // addu $10,$9,$0 reads the last write-back
        step(STATE_ID, 32'h0120_5021, 32'd0);
        checks++; if (bus.rs_data !== 32'h0000_ABCD) begin errors++; $display("FAIL wrap_reg9: got %h want 0000abcd", bus.rs_data); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.state = STATE_IF;
        bus.instruction = 32'd0;
        bus.wb_data = 32'd0;
        test_reset();
        test_addiu();
        test_sign_ext();
        test_operands();
        test_reg0();
        test_reset_midop();
        test_illegal();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
